// File: rtl/multdiv_sequencer.sv
// Sequences the shared iterative multiplier/divider: accepts one MUL/DIV issue,
// pulses start, stalls until ready or timeout, then presents a one-cycle writeback.
module multdiv_sequencer #(
  parameter logic [4:0] OP_MUL  = 5'b00110,
  parameter logic [4:0] OP_DIV  = 5'b00111,
  parameter int         TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_opcode,
  input  logic [31:0] issue_opA,
  input  logic [31:0] issue_opB,
  input  logic [4:0]  issue_rd,
  input  logic        flush,
  input  logic [31:0] md_result,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall,
  output logic        busy,
  output logic        wb_valid,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd,
  output logic        wb_exception
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, BUSY = 2'd2, DONE = 2'd3} state_t;

  state_t        state, state_next;
  logic [CW-1:0] counter;
  logic [31:0]   op_a, op_b, res_q;
  logic [4:0]    rd_q;
  logic          is_div, exc_q;
  logic          is_md, accept, capture, timed_out;

  assign is_md = issue_valid & ((issue_opcode == OP_MUL) | (issue_opcode == OP_DIV));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next   = state;
    accept       = 1'b0;
    capture      = 1'b0;
    timed_out    = 1'b0;
    stall        = 1'b0;
    busy         = 1'b0;
    md_ctrl_MULT = 1'b0;
    md_ctrl_DIV  = 1'b0;
    wb_valid     = 1'b0;
    case (state)
      IDLE: begin
        accept = is_md & ~flush;
        stall  = accept;
        if (accept) state_next = START;
      end
      START: begin
        // any md_resultRDY seen here is left over from a previous operation
        stall        = 1'b1;
        busy         = 1'b1;
        md_ctrl_MULT = ~is_div;
        md_ctrl_DIV  = is_div;
        state_next   = flush ? IDLE : BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        busy  = 1'b1;
        if (flush) begin
          state_next = IDLE;
        end else if (md_resultRDY) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (counter == CW'(TIMEOUT - 1)) begin
          timed_out  = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        wb_valid   = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a    <= '0;
      op_b    <= '0;
      rd_q    <= '0;
      is_div  <= 1'b0;
      counter <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= issue_opA;
        op_b   <= issue_opB;
        rd_q   <= issue_rd;
        is_div <= (issue_opcode == OP_DIV);
      end
      if (state == START)
        counter <= '0;
      else if (state == BUSY && counter != CW'(TIMEOUT))
        counter <= counter + 1'b1;
      if (capture) begin
        res_q <= md_result;
        exc_q <= md_exception;
      end else if (timed_out) begin
        res_q <= '0;
        exc_q <= 1'b1;
      end
    end
  end

  assign md_opA       = (state != IDLE) ? op_a : '0;
  assign md_opB       = (state != IDLE) ? op_b : '0;
  assign wb_result    = wb_valid ? res_q : '0;
  assign wb_rd        = wb_valid ? rd_q : '0;
  assign wb_exception = wb_valid & exc_q;
endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: a behavioural multdiv model plus a writeback
// scoreboard, driven from a vector table and a few hand-written sequences.
`timescale 1ns/1ps
module tb_multdiv_sequencer;
  localparam logic [4:0] OP_MUL = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_opcode = '0;
  logic [31:0] issue_opA = '0;
  logic [31:0] issue_opB = '0;
  logic [4:0]  issue_rd = '0;
  logic        flush = 1'b0;
  logic [31:0] md_result = '0;
  logic        md_resultRDY = 1'b0;
  logic        md_exception = 1'b0;
  logic        md_ctrl_MULT, md_ctrl_DIV, stall, busy, wb_valid, wb_exception;
  logic [31:0] md_opA, md_opB, wb_result;
  logic [4:0]  wb_rd;

  always #5 clk = ~clk;

  multdiv_sequencer dut (
    .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_opcode(issue_opcode),
    .issue_opA(issue_opA), .issue_opB(issue_opB), .issue_rd(issue_rd), .flush(flush),
    .md_result(md_result), .md_resultRDY(md_resultRDY), .md_exception(md_exception),
    .md_ctrl_MULT(md_ctrl_MULT), .md_ctrl_DIV(md_ctrl_DIV), .md_opA(md_opA), .md_opB(md_opB),
    .stall(stall), .busy(busy), .wb_valid(wb_valid), .wb_result(wb_result), .wb_rd(wb_rd),
    .wb_exception(wb_exception)
  );

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        exc;
  } exp_t;

  typedef struct {
    string       name;
    logic [4:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        flush;
    int          delay;   // cycles from start pulse to RDY; 0 = never
    logic        stale;   // hold RDY high during START
    logic [31:0] md_res;
    logic        md_exc;
    logic        accept;
    logic [31:0] exp_res;
    logic        exp_exc;
  } vec_t;

  exp_t sb[$];
  exp_t e;
  vec_t vecs[8];
  vec_t v_flush, v_div2, v_b1, v_b2, v_abort;

  int checks = 0, errors = 0;
  int model_delay = 0;
  logic model_stale = 1'b0;
  logic [31:0] model_res = '0;
  logic model_exc = 1'b0;
  int md_cnt = 0;
  int mul_pulses = 0, div_pulses = 0, stall_cycles = 0, wb_count = 0;
  int base_mul = 0, base_div = 0, base_stall = 0, base_wb = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // multdiv model: counts from the start pulse, then returns the programmed result
  always @(negedge clk) begin
    if (md_ctrl_MULT || md_ctrl_DIV) begin
      md_cnt       <= model_delay;
      md_resultRDY <= model_stale;
      md_result    <= $urandom;
      md_exception <= 1'b0;
    end else if (md_cnt == 1) begin
      md_cnt       <= 0;
      md_resultRDY <= 1'b1;
      md_result    <= model_res;
      md_exception <= model_exc;
    end else begin
      if (md_cnt > 1) md_cnt <= md_cnt - 1;
      md_resultRDY <= 1'b0;
      md_result    <= $urandom;
      md_exception <= 1'b0;
    end
  end

  // monitor: activity counters and writeback scoreboard
  always @(negedge clk) begin
    #2;
    if (md_ctrl_MULT) mul_pulses++;
    if (md_ctrl_DIV) div_pulses++;
    if (stall) stall_cycles++;
    if (wb_valid) begin
      wb_count++;
      if (sb.size() == 0) begin
        chk("unexpected_wb_valid", {31'b0, wb_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_result", wb_result, e.result);
        chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
        chk("wb_exception", {31'b0, wb_exception}, {31'b0, e.exc});
        $display("writeback rd=%0d result=%h exc=%0b", wb_rd, wb_result, wb_exception);
      end
    end
  end

  task automatic start_op(input vec_t v, input bit push);
    model_delay  = v.delay;
    model_stale  = v.stale;
    model_res    = v.md_res;
    model_exc    = v.md_exc;
    issue_valid  = 1'b1;
    issue_opcode = v.opcode;
    issue_opA    = v.a;
    issue_opB    = v.b;
    issue_rd     = v.rd;
    flush        = v.flush;
    base_stall   = stall_cycles;
    base_mul     = mul_pulses;
    base_div     = div_pulses;
    base_wb      = wb_count;
    if (push && v.accept) sb.push_back('{v.exp_res, v.rd, v.exp_exc});
  endtask

  // called at negedge+1 of the cycle after acceptance; returns at negedge+1 of DONE
  task automatic wait_wb(input int exp_lat, input string name);
    int n;
    n = 1;
    while (!wb_valid && n < 100) begin
      @(negedge clk);
      n++;
      #1;
    end
    chk({name, "_latency"}, n, exp_lat);
  endtask

  // called at the issue negedge, after start_op
  task automatic finish_op(input vec_t v);
    int exp_lat;
    exp_lat = (v.delay == 0) ? 42 : v.delay + 2;
    #1;
    chk({v.name, "_stall_issue"}, {31'b0, stall}, {31'b0, v.accept});
    @(negedge clk);
    issue_valid  = 1'b0;
    issue_opcode = '0;
    flush        = 1'b0;
    #1;
    chk({v.name, "_mul_pulse"}, {31'b0, md_ctrl_MULT}, {31'b0, v.accept && v.opcode == OP_MUL});
    chk({v.name, "_div_pulse"}, {31'b0, md_ctrl_DIV}, {31'b0, v.accept && v.opcode == OP_DIV});
    chk({v.name, "_busy"}, {31'b0, busy}, {31'b0, v.accept});
    if (v.accept) begin
      chk({v.name, "_md_opA"}, md_opA, v.a);
      chk({v.name, "_md_opB"}, md_opB, v.b);
      wait_wb(exp_lat, v.name);
    end
    @(negedge clk);
    #3;
    chk({v.name, "_wb_drop"}, {31'b0, wb_valid}, 32'd0);
    chk({v.name, "_wb_result_idle"}, wb_result, 32'd0);
    chk({v.name, "_md_opA_idle"}, md_opA, 32'd0);
    chk({v.name, "_stall_cycles"}, stall_cycles - base_stall, v.accept ? exp_lat : 0);
    chk({v.name, "_mul_count"}, mul_pulses - base_mul, (v.accept && v.opcode == OP_MUL) ? 1 : 0);
    chk({v.name, "_div_count"}, div_pulses - base_div, (v.accept && v.opcode == OP_DIV) ? 1 : 0);
    chk({v.name, "_wb_count"}, wb_count - base_wb, v.accept ? 1 : 0);
    $display("op %s done", v.name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"mul_7x-3", OP_MUL, 32'd7, 32'hFFFFFFFD, 5'd5, 1'b0, 32, 1'b0,
                32'hFFFFFFEB, 1'b0, 1'b1, 32'hFFFFFFEB, 1'b0};
    vecs[1] = '{"div_by0", OP_DIV, 32'd100, 32'd0, 5'd9, 1'b0, 20, 1'b0,
                32'hFFFFFFFF, 1'b1, 1'b1, 32'hFFFFFFFF, 1'b1};
    vecs[2] = '{"timeout", OP_MUL, 32'd3, 32'd4, 5'd7, 1'b0, 0, 1'b1,
                32'd12, 1'b0, 1'b1, 32'd0, 1'b1};
    vecs[3] = '{"div_fast", OP_DIV, 32'd50, 32'd7, 5'd12, 1'b0, 1, 1'b0,
                32'd7, 1'b0, 1'b1, 32'd7, 1'b0};
    vecs[4] = '{"non_md", 5'b00000, 32'd1, 32'd2, 5'd1, 1'b0, 0, 1'b0,
                32'd0, 1'b0, 1'b0, 32'd0, 1'b0};
    vecs[5] = '{"rdy_at_timeout", OP_MUL, 32'd2, 32'd3, 5'd2, 1'b0, 40, 1'b0,
                32'd6, 1'b0, 1'b1, 32'd6, 1'b0};
    vecs[6] = '{"flush_at_issue", OP_DIV, 32'd1, 32'd1, 5'd6, 1'b1, 3, 1'b0,
                32'd1, 1'b0, 1'b0, 32'd0, 1'b0};
    vecs[7] = '{"add_opcode", 5'b00101, 32'd9, 32'd9, 5'd3, 1'b0, 0, 1'b0,
                32'd0, 1'b0, 1'b0, 32'd0, 1'b0};
    v_flush = '{"flushed_mul", OP_MUL, 32'd11, 32'd13, 5'd8, 1'b0, 10, 1'b0,
                32'd143, 1'b0, 1'b1, 32'd143, 1'b0};
    v_div2  = '{"div_after_flush", OP_DIV, 32'd81, 32'd9, 5'd10, 1'b0, 12, 1'b0,
                32'd9, 1'b0, 1'b1, 32'd9, 1'b0};
    v_b1    = '{"b2b_first", OP_MUL, 32'd6, 32'd7, 5'd3, 1'b0, 5, 1'b0,
                32'd42, 1'b0, 1'b1, 32'd42, 1'b0};
    v_b2    = '{"b2b_second", OP_MUL, 32'd8, 32'd9, 5'd4, 1'b0, 6, 1'b0,
                32'd72, 1'b0, 1'b1, 32'd72, 1'b0};
    v_abort = '{"reset_abort", OP_MUL, 32'd5, 32'd5, 5'd11, 1'b0, 0, 1'b0,
                32'd25, 1'b0, 1'b1, 32'd0, 1'b0};

    // reset state
    #2;
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("rst_md_opA", md_opA, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start_op(vecs[i], 1'b1);
      finish_op(vecs[i]);
    end

    // flush in the same BUSY cycle as ready, then a fresh DIV the next cycle
    @(negedge clk);
    start_op(v_flush, 1'b0);
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_busy_before", {31'b0, busy}, 32'd1);
    chk("flush_rdy_present", {31'b0, md_resultRDY}, 32'd1);
    @(negedge clk);
    start_op(v_div2, 1'b1);
    #1;
    chk("flush_idle_after", {31'b0, busy}, 32'd0);
    chk("flush_no_wb", {31'b0, wb_valid}, 32'd0);
    finish_op(v_div2);

    // back-to-back: second issue held through DONE, accepted in the next IDLE
    @(negedge clk);
    start_op(v_b1, 1'b1);
    @(negedge clk);
    issue_valid = 1'b0;
    #1;
    wait_wb(7, "b2b_first");
    #2;
    start_op(v_b2, 1'b1);
    #1;
    chk("b2b_done_stall", {31'b0, stall}, 32'd0);
    chk("b2b_done_wb", {31'b0, wb_valid}, 32'd1);
    @(negedge clk);
    finish_op(v_b2);

    // asynchronous reset in the middle of BUSY
    @(negedge clk);
    start_op(v_abort, 1'b0);
    @(negedge clk);
    issue_valid = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("abort_busy", {31'b0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_stall", {31'b0, stall}, 32'd0);
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_mul", {31'b0, md_ctrl_MULT}, 32'd0);
    chk("arst_md_opA", md_opA, 32'd0);
    chk("arst_md_opB", md_opB, 32'd0);
    chk("arst_wb_valid", {31'b0, wb_valid}, 32'd0);
    chk("arst_wb_rd", {27'b0, wb_rd}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    base_mul = mul_pulses;
    base_div = div_pulses;
    issue_valid  = 1'b1;
    issue_opcode = 5'b00000;
    #1;
    chk("post_rst_nop_stall", {31'b0, stall}, 32'd0);
    @(negedge clk);
    issue_valid = 1'b0;
    #3;
    chk("post_rst_busy", {31'b0, busy}, 32'd0);
    chk("post_rst_pulses", (mul_pulses - base_mul) + (div_pulses - base_div), 32'd0);

    // normal operation after reset
    @(negedge clk);
    start_op(vecs[0], 1'b1);
    finish_op(vecs[0]);

    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
